// File: rtl/add_pipe.sv
// add_pipe: WIDTH-bit pipelined adder/subtractor. Each register stage resolves one
// SEG-bit carry-ripple segment; valid/ready flow control with carry-out and overflow.
module add_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int S = WIDTH / SEG;

  // {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], ci);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  for (genvar k = 0; k < S; k++) begin : stg
    localparam int IW = WIDTH - k * SEG;  // operand bits not yet consumed on entry

    logic [IW-1:0]        op_a_s;
    logic [IW-1:0]        op_b_s;
    logic                 c_in_s;
    logic                 v_in_s;
    logic                 rdy_s;
    logic [SEG-1:0]       seg_sum_s;
    logic [SEG:0]         carry_s;
    logic [(k+1)*SEG-1:0] sum_nxt_s;
    logic [(k+1)*SEG-1:0] sum_r;
    logic                 v_r;
    logic                 c_r;

    // Subtraction is folded in at entry (invert B, force carry-in) and travels with the beat.
    if (k == 0) begin : head
      assign op_a_s    = a;
      assign op_b_s    = sub ? ~b : b;
      assign c_in_s    = sub | cin;
      assign v_in_s    = in_valid;
      assign sum_nxt_s = seg_sum_s;
    end else begin : chain
      assign op_a_s    = stg[k-1].skew.a_r;
      assign op_b_s    = stg[k-1].skew.b_r;
      assign c_in_s    = stg[k-1].c_r;
      assign v_in_s    = stg[k-1].v_r;
      assign sum_nxt_s = {seg_sum_s, stg[k-1].sum_r};
    end

    if (k == S - 1) begin : rdy_end
      assign rdy_s = ~v_r | out_ready;
    end else begin : rdy_mid
      assign rdy_s = ~v_r | stg[k+1].rdy_s;
    end

    // Carry-ripple across this stage's SEG bits.
    always_comb begin
      logic [1:0] fa_s;
      fa_s       = 2'b00;
      carry_s    = {(SEG+1){1'b0}};
      seg_sum_s  = {SEG{1'b0}};
      carry_s[0] = c_in_s;
      for (int i = 0; i < SEG; i++) begin
        fa_s           = full_add(op_a_s[i], op_b_s[i], carry_s[i]);
        seg_sum_s[i]   = fa_s[0];
        carry_s[i+1]   = fa_s[1];
      end
    end

    // Stage valid, carry and accumulated sum; advance only when downstream can take it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= {((k+1)*SEG){1'b0}};
      end else if (rdy_s) begin
        v_r   <= v_in_s;
        c_r   <= carry_s[SEG];
        sum_r <= sum_nxt_s;
      end
    end

    if (k < S - 1) begin : skew
      logic [IW-SEG-1:0] a_r;
      logic [IW-SEG-1:0] b_r;

      // Skew buffers carry the operand bits later stages still need.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= {(IW-SEG){1'b0}};
          b_r <= {(IW-SEG){1'b0}};
        end else if (rdy_s) begin
          a_r <= op_a_s[IW-1:SEG];
          b_r <= op_b_s[IW-1:SEG];
        end
      end
    end

    if (k == S - 1) begin : last
      logic ovf_r;

      // Overflow: carry into the MSB disagrees with carry out of it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_r <= 1'b0;
        end else if (rdy_s) begin
          ovf_r <= carry_s[SEG] ^ carry_s[SEG-1];
        end
      end
    end
  end

  assign in_ready  = stg[0].rdy_s;
  assign out_valid = stg[S-1].v_r;
  assign sum       = stg[S-1].sum_r;
  assign cout      = stg[S-1].c_r;
  assign ovf       = stg[S-1].last.ovf_r;

endmodule

// File: tb/tb_add_pipe.sv
// Self-checking bench for add_pipe: a 16/4 instance (4 stages) and an 8/8 instance
// (1 stage), checked against an integer-arithmetic reference model.
module tb_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv, ir, ci, sb, ov, ordy, co, of;
  logic [15:0] a, b, s;
  logic        iv8, ir8, ci8, sb8, ov8, ordy8, co8, of8;
  logic [7:0]  a8, b8, s8;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [17:0] r;
    int          t;
  } beat_t;

  beat_t q[$];

  add_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .ovf(of)
  );

  add_pipe #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(ordy8), .sum(s8), .cout(co8), .ovf(of8)
  );

  // Reference: {ovf, cout, sum} from unsigned and signed integer arithmetic of width w.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic sub_op);
    longint m, ux, uy, sx, sy, cc, us, ss;
    logic co_m, ov_m;
    logic [15:0] res;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    cc = 0;
    if (!sub_op && c) cc = 1;
    if (sub_op) begin
      us = ux - uy;
      ss = sx - sy;
      co_m = (ux >= uy);
    end else begin
      us = ux + uy + cc;
      ss = sx + sy + cc;
      co_m = (us >= m);
    end
    ov_m = (ss >= m / 2) || (ss < -(m / 2));
    us  = us & (m - 1);
    res = us[15:0];
    return {ov_m, co_m, res};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  // Offers one beat to the 16-bit DUT and waits (bounded) for its result.
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic sub_op,
                       output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    int t0;
    rs = 16'h0; rc = 1'b0; ro = 1'b0; lat = -1;
    next_cycle();
    iv = 1'b1; a = x; b = y; ci = c; sb = sub_op; ordy = 1'b1;
    #1;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      iv = 1'b0;
      #1;
      if (ov === 1'b1) begin
        rs = s; rc = co; ro = of; lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sub_op,
                      output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    int t0;
    rs = 8'h0; rc = 1'b0; ro = 1'b0; lat = -1;
    next_cycle();
    iv8 = 1'b1; a8 = x; b8 = y; ci8 = c; sb8 = sub_op; ordy8 = 1'b1;
    #1;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      iv8 = 1'b0;
      #1;
      if (ov8 === 1'b1) begin
        rs = s8; rc = co8; ro = of8; lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int spurious;
    rst_n = 1'b0;
    iv = 1'b1; a = 16'($urandom); b = 16'($urandom); ci = 1'b1; sb = 1'b0; ordy = 1'b1;
    iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'b1; sb8 = 1'b0; ordy8 = 1'b1;
    repeat (3) next_cycle();
    #1;
    n_cmp++;
    if (ov !== 1'b0 || s !== 16'h0000 || co !== 1'b0 || of !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state16: out_valid=%b sum=%h cout=%b ovf=%b, want 0 0000 0 0", ov, s, co, of);
    end
    n_cmp++;
    if (ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state8: out_valid=%b sum=%h cout=%b ovf=%b, want 0 00 0 0", ov8, s8, co8, of8);
    end
    next_cycle();
    rst_n = 1'b1; iv = 1'b0; iv8 = 1'b0;
    #1;
    n_cmp++;
    if (ir !== 1'b1 || ir8 !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: in_ready16=%b in_ready8=%b, want 1 1", ir, ir8);
    end
    spurious = 0;
    repeat (6) begin
      next_cycle();
      #1;
      if (ov !== 1'b0 || ov8 !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL no_spurious_beat: %0d cycles with out_valid, want 0", spurious);
    end
  endtask

  task automatic test_add_wrap();
    logic [15:0] rs; logic rc, ro; int lat;
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    n_cmp++;
    if ({rs, rc, ro} !== {16'h0000, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL add_ffff_1: sum=%h cout=%b ovf=%b, want 0000 1 0", rs, rc, ro);
    end
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL add_latency: got %0d, want 4", lat); end
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
    n_cmp++;
    if ({rs, rc, ro} !== {16'h8000, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL add_7fff_1: sum=%h cout=%b ovf=%b, want 8000 0 1", rs, rc, ro);
    end
  endtask

  task automatic test_sub();
    logic [15:0] rs; logic rc, ro; int lat;
    run16(16'h8000, 16'h0001, 1'b1, 1'b1, rs, rc, ro, lat);
    n_cmp++;
    if ({rs, rc, ro} !== {16'h7FFF, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sub_8000_1: sum=%h cout=%b ovf=%b, want 7fff 1 1", rs, rc, ro);
    end
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL sub_latency: got %0d, want 4", lat); end
    run16(16'h0003, 16'h0005, 1'b0, 1'b1, rs, rc, ro, lat);
    n_cmp++;
    if ({rs, rc, ro} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL sub_3_5: sum=%h cout=%b ovf=%b, want fffe 0 0", rs, rc, ro);
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got  = 0;
    int errs = 0;
    beat_t e;
    q.delete();
    for (int t = 0; t < 2000 && got < 200; t++) begin
      next_cycle();
      iv = (sent < 200); a = 16'($urandom); b = 16'($urandom);
      ci = 1'($urandom); sb = 1'($urandom); ordy = 1'b1;
      #1;
      if (ov === 1'b1) begin
        if (q.size() == 0) begin
          errs++;
          $display("FAIL stream_extra: unexpected result %h", s);
        end else begin
          e = q.pop_front();
          got++;
          n_cmp++;
          if ({of, co, s} !== e.r || (cyc - e.t) != 4) begin
            n_bad++;
            $display("FAIL stream_beat: got %h lat %0d, want %h lat 4", {of, co, s}, cyc - e.t, e.r);
          end
        end
      end
      if (iv && ir !== 1'b1) errs++;
      if (iv && ir === 1'b1) begin
        q.push_back('{ref_model(16, a, b, ci, sb), cyc});
        sent++;
      end
    end
    iv = 1'b0;
    n_cmp++;
    if (got != 200 || errs != 0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got %0d errs %0d left %0d, want 200 0 0", got, errs, q.size());
    end
  endtask

  task automatic test_back_pressure();
    int sent = 0;
    int got  = 0;
    logic stalled = 1'b0;
    logic [17:0] held = 18'h0;
    logic exp_rdy;
    beat_t e;
    q.delete();
    for (int t = 0; t < 5000 && got < 200; t++) begin
      next_cycle();
      iv = (sent < 200) && ($urandom_range(1) == 1);
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      ordy = 1'($urandom);
      #1;
      exp_rdy = ordy || (q.size() < 4);
      n_cmp++;
      if (ir !== exp_rdy) begin
        n_bad++;
        $display("FAIL bp_in_ready: got %b, want %b (occupancy %0d)", ir, exp_rdy, q.size());
      end
      if (stalled) begin
        n_cmp++;
        if (ov !== 1'b1 || {of, co, s} !== held) begin
          n_bad++;
          $display("FAIL bp_stall_hold: out_valid=%b out=%h, want 1 %h", ov, {of, co, s}, held);
        end
      end
      if (ov === 1'b1 && ordy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: unexpected result %h, want none", {of, co, s});
        end else begin
          e = q.pop_front();
          got++;
          if ({of, co, s} !== e.r) begin
            n_bad++;
            $display("FAIL bp_beat: got %h, want %h", {of, co, s}, e.r);
          end
        end
      end
      if (iv && ir === 1'b1) begin
        q.push_back('{ref_model(16, a, b, ci, sb), cyc});
        sent++;
      end
      stalled = (ov === 1'b1) && !ordy;
      held    = {of, co, s};
    end
    iv = 1'b0;
    n_cmp++;
    if (got != 200 || q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d left %0d, want 200 0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int spurious = 0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      iv = 1'b1; a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      ordy = 1'b1;
      #1;
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    next_cycle();
    rst_n = 1'b1; iv = 1'b0;
    #1;
    n_cmp++;
    if (ov !== 1'b0 || s !== 16'h0000 || co !== 1'b0 || of !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_state: out_valid=%b sum=%h cout=%b ovf=%b, want 0 0000 0 0", ov, s, co, of);
    end
    repeat (8) begin
      next_cycle();
      #1;
      if (ov !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious != 0) begin
      n_bad++;
      $display("FAIL midreset_flush: %0d beats emerged, want 0", spurious);
    end
  endtask

  task automatic test_small_config();
    logic [7:0] rs; logic rc, ro; int lat;
    logic [7:0] xs [4] = '{8'hFF, 8'h7F, 8'h80, 8'h03};
    logic [7:0] ys [4] = '{8'h01, 8'h01, 8'h01, 8'h05};
    logic       ss [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] want [4] = '{{8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1},
                             {8'h7F, 1'b1, 1'b1}, {8'hFE, 1'b0, 1'b0}};
    for (int k = 0; k < 4; k++) begin
      run8(xs[k], ys[k], 1'b0, ss[k], rs, rc, ro, lat);
      n_cmp++;
      if ({rs, rc, ro} !== want[k] || lat != 1) begin
        n_bad++;
        $display("FAIL s1_vector%0d: out=%h lat %0d, want %h lat 1", k, {rs, rc, ro}, lat, want[k]);
      end
    end
    for (int k = 0; k < 40; k++) begin
      logic [17:0] r;
      logic [7:0] x, y; logic c, so;
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom); so = 1'($urandom);
      r = ref_model(8, {8'h00, x}, {8'h00, y}, c, so);
      run8(x, y, c, so, rs, rc, ro, lat);
      n_cmp++;
      if ({ro, rc, rs} !== {r[17:16], r[7:0]} || lat != 1) begin
        n_bad++;
        $display("FAIL s1_random: out=%h lat %0d, want %h lat 1", {ro, rc, rs}, lat, {r[17:16], r[7:0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_stream();
    test_back_pressure();
    test_reset_midstream();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
